// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Fetch/issue stage for the 9-bit processor. Owns the program counter,
//   prefetches words from a synchronous ROM into a 2-entry buffer and issues
//   them on the processor DIN bus with Run. The processor's Done pulse paces
//   issue.
//
// Ports
//   Clock     in   system clock, rising edge
//   Resetn    in   synchronous active-low reset
//   Enable    in   1 = fetch and issue; 0 = finish current instruction, idle
//   MemAddr   out  ROM read address (registered)
//   MemData   in   ROM data, valid one cycle after MemAddr
//   InstrOut  out  processor DIN (instruction word or mvi immediate)
//   Run       out  InstrOut holds a new instruction this cycle
//   Done      in   processor last-step pulse
//   PC        out  address of the most recently issued instruction
//   Busy      out  instruction issued, Done not yet seen
//   Halted    out  (HALT_DETECT_EN only) opcode 3'b111 reached, stopped
//
// Build option: define HALT_DETECT_EN to stop on opcode 3'b111 instead of
// issuing it.

module instr_fetch_unit #(
  parameter int ADDR_W = 5,
  parameter int WORD_W = 9
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Enable,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic [WORD_W-1:0] MemData,
  output logic [WORD_W-1:0] InstrOut,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] PC,
  output logic              Busy
`ifdef HALT_DETECT_EN
  ,output logic             Halted
`endif
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_IMM, S_WAIT, S_HALT} state_e;

  localparam logic [2:0] OP_MVI = 3'b001;
`ifdef HALT_DETECT_EN
  localparam logic [2:0] OP_HALT = 3'b111;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              busy_q, busy_d;
  logic              inflight_q;
  logic [1:0]        count_q, count_d;
  // Buffer entry 0 is the head; each entry keeps its ROM address for PC.
  logic [WORD_W-1:0] bw_q [2];
  logic [WORD_W-1:0] bw_d [2];
  logic [ADDR_W-1:0] ba_q [2];
  logic [ADDR_W-1:0] ba_d [2];

  logic [2:0] head_op;
  logic       head_mvi, head_rdy, pop, rd_en, push_idx;
  logic [1:0] fill, cnt_pop;

  assign head_op  = bw_q[0][WORD_W-1 -: 3];
  assign head_mvi = (head_op == OP_MVI);
  // mvi may only issue once its immediate is already buffered behind it.
  assign head_rdy = ((count_q != 2'd0) && !head_mvi) || (count_q == 2'd2);

  // Issue FSM
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    pc_d     = pc_q;
    Run      = 1'b0;
    InstrOut = '0;
    pop      = 1'b0;
    case (state_q)
      S_IDLE: if (Enable) state_d = S_ISSUE;
      S_ISSUE: begin
        if (!Enable) begin
          state_d = S_IDLE;
        end else if (head_rdy) begin
`ifdef HALT_DETECT_EN
          if (head_op == OP_HALT) state_d = S_HALT;
          else
`endif
          begin
            Run      = 1'b1;
            InstrOut = bw_q[0];
            pop      = 1'b1;
            pc_d     = ba_q[0];
            busy_d   = 1'b1;
            state_d  = head_mvi ? S_IMM : S_WAIT;
          end
        end
      end
      S_IMM: begin
        InstrOut = bw_q[0];
        pop      = 1'b1;
        if (Done) begin
          busy_d  = 1'b0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (Done) begin
          busy_d  = 1'b0;
          state_d = Enable ? S_ISSUE : S_IDLE;
        end
      end
`ifdef HALT_DETECT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // Prefetch: in-flight read counts against capacity so the buffer never
  // overflows when the data lands.
  always_comb begin
    fill  = count_q + {1'b0, inflight_q};
    rd_en = Enable && (fill < 2'd2);
`ifdef HALT_DETECT_EN
    if (state_q == S_HALT) rd_en = 1'b0;
`endif
  end

  // Buffer update: pop shifts first, then the arriving word lands behind
  // whatever remains, preserving order when both happen together.
  always_comb begin
    bw_d     = bw_q;
    ba_d     = ba_q;
    cnt_pop  = count_q - {1'b0, pop};
    push_idx = (cnt_pop != 2'd0);
    if (pop) begin
      bw_d[0] = bw_q[1];
      ba_d[0] = ba_q[1];
    end
    if (inflight_q) begin
      // MemAddr advanced when the read issued, so the read address is one back.
      bw_d[push_idx] = MemData;
      ba_d[push_idx] = mem_addr_q - ADDR_W'(1);
    end
    count_d = cnt_pop + {1'b0, inflight_q};
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state_q    <= S_IDLE;
      mem_addr_q <= '0;
      pc_q       <= '0;
      busy_q     <= 1'b0;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      bw_q[0]    <= '0;
      bw_q[1]    <= '0;
      ba_q[0]    <= '0;
      ba_q[1]    <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      busy_q     <= busy_d;
      inflight_q <= rd_en;
      count_q    <= count_d;
      bw_q       <= bw_d;
      ba_q       <= ba_d;
      if (rd_en) mem_addr_q <= mem_addr_q + ADDR_W'(1);
    end
  end

  assign MemAddr = mem_addr_q;
  assign PC      = pc_q;
  assign Busy    = busy_q;
`ifdef HALT_DETECT_EN
  assign Halted  = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit
//   Bench for instr_fetch_unit (ADDR_W=2 so address wrap is short). A
//   queue-based model of the prefetch buffer and instruction life cycle is
//   compared against the DUT every cycle; directed scenarios add literal
//   expectations. Works with or without HALT_DETECT_EN.

module tb_instr_fetch_unit;
  localparam int AW    = 2;
  localparam int WW    = 9;
  localparam int DEPTH = 1 << AW;
`ifdef HALT_DETECT_EN
  localparam bit HALT_ON = 1'b1;
`else
  localparam bit HALT_ON = 1'b0;
`endif

  logic          Clock = 1'b0;
  logic          Resetn = 1'b0;
  logic          Enable = 1'b0;
  logic          Done = 1'b0;
  logic [WW-1:0] MemData = '0;
  logic [AW-1:0] MemAddr, PC;
  logic [WW-1:0] InstrOut;
  logic          Run, Busy;
`ifdef HALT_DETECT_EN
  logic          Halted;
`endif

  instr_fetch_unit #(.ADDR_W(AW), .WORD_W(WW)) dut (
    .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
    .MemAddr(MemAddr), .MemData(MemData), .InstrOut(InstrOut),
    .Run(Run), .Done(Done), .PC(PC), .Busy(Busy)
`ifdef HALT_DETECT_EN
    ,.Halted(Halted)
`endif
  );

  always #5 Clock = ~Clock;

  // Synchronous ROM
  logic [WW-1:0] rom [DEPTH];
  always @(posedge Clock) MemData <= rom[MemAddr];

  int n_chk = 0;
  int n_fail = 0;
  bit auto_done = 0, force_done = 0, last_run = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0o expected %0o at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] opc(input logic [WW-1:0] w);
    return w[WW-1 -: 3];
  endfunction

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [AW-1:0] a;
    logic [WW-1:0] w;
  } ent_t;
  ent_t mq[$];
  bit            m_inf = 0, m_on = 0, m_busy = 0, m_imm = 0, m_halt = 0;
  logic [AW-1:0] m_inf_a = '0, m_maddr = '0, m_pc = '0;

  function automatic bit head_ready();
    if (mq.size() >= 2) return 1'b1;
    if (mq.size() == 1) return opc(mq[0].w) != 3'b001;
    return 1'b0;
  endfunction

  always @(posedge Clock) begin : model
    bit rd;
    if (!Resetn) begin
      mq.delete();
      m_inf = 0; m_inf_a = '0; m_maddr = '0; m_pc = '0;
      m_on = 0; m_busy = 0; m_imm = 0; m_halt = 0;
    end else begin
      rd = Enable && !m_halt && ((mq.size() + int'(m_inf)) < 2);
      if (!m_on) begin
        m_on = Enable;
      end else if (m_halt) begin
        m_halt = 1;
      end else if (!m_busy) begin
        if (!Enable) m_on = 0;
        else if (head_ready()) begin
          if (HALT_ON && opc(mq[0].w) == 3'b111) m_halt = 1;
          else begin
            m_pc   = mq[0].a;
            m_busy = 1;
            m_imm  = (opc(mq[0].w) == 3'b001);
            void'(mq.pop_front());
          end
        end
      end else if (m_imm) begin
        void'(mq.pop_front());
        m_imm = 0;
        if (Done) m_busy = 0;
      end else if (Done) begin
        m_busy = 0;
        m_on   = Enable;
      end
      if (m_inf) mq.push_back('{a: m_inf_a, w: rom[m_inf_a]});
      m_inf = rd;
      if (rd) begin
        m_inf_a = m_maddr;
        m_maddr = m_maddr + 1'b1;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge Clock) begin : cmp
    bit            e_run;
    logic [WW-1:0] e_instr;
    e_run = m_on && !m_busy && !m_halt && Enable && head_ready()
            && !(HALT_ON && opc(mq[0].w) == 3'b111);
    if (e_run) e_instr = mq[0].w;
    else if (m_busy && m_imm && mq.size() > 0) e_instr = mq[0].w;
    else e_instr = '0;
    chk("m_run", Run, e_run);
    chk("m_instr", InstrOut, e_instr);
    chk("m_pc", PC, m_pc);
    chk("m_busy", Busy, m_busy);
    chk("m_maddr", MemAddr, m_maddr);
`ifdef HALT_DETECT_EN
    chk("m_halted", Halted, m_halt);
`endif
    last_run = (Run === 1'b1);
  end

  // Processor stand-in: Done in the cycle after Run (T1) when auto_done.
  always @(posedge Clock) begin
    #2;
    Done = force_done | (auto_done & last_run);
  end

  // ---------------- directed stimulus ----------------
  task automatic tick; @(posedge Clock); #1; endtask
  task automatic obs; @(negedge Clock); endtask

  task automatic do_reset(input logic [WW-1:0] w0, w1, w2, w3, input bit ad);
    tick;
    Resetn = 0; Enable = 1; auto_done = ad; force_done = 0;
    rom[0] = w0; rom[1] = w1; rom[2] = w2; rom[3] = w3;
    tick; obs;
    chk("rst_run", Run, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_pc", PC, 0);
    chk("rst_maddr", MemAddr, 0);
    chk("rst_instr", InstrOut, 0);
    tick; Resetn = 1; obs;   // cycle 1 observed on return
  endtask

  task automatic wait_run(input string nm, input int lim);
    bit seen = 0;
    for (int i = 0; i < lim && !seen; i++) begin
      tick; obs;
      if (Run === 1'b1) seen = 1;
    end
    chk(nm, seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    obs;

    // 1: mvi then mv, Done in T1
    do_reset(9'o100, 9'd5, 9'o010, 9'o000, 1);
    chk("t1_c1_run", Run, 0);
    tick; obs;
    tick; obs; chk("t1_c3_run", Run, 0);
    tick; obs; chk("t1_c4_run", Run, 1); chk("t1_c4_instr", InstrOut, 9'o100);
    tick; obs; chk("t1_imm_run", Run, 0); chk("t1_imm", InstrOut, 9'd5); chk("t1_pc0", PC, 0);
    wait_run("t1_run2", 6); chk("t1_instr2", InstrOut, 9'o010);
    tick; obs; chk("t1_pc2", PC, 2);

    // 2: add held without Done fills buffer and freezes MemAddr
    do_reset(9'o201, 9'o202, 9'o203, 9'o204, 0);
    tick; obs;
    tick; obs; chk("t2_c3_run", Run, 1); chk("t2_c3_instr", InstrOut, 9'o201);
    for (int i = 0; i < 5; i++) begin tick; obs; chk("t2_hold_run", Run, 0); end
    chk("t2_maddr", MemAddr, 3); chk("t2_busy", Busy, 1);
    tick; force_done = 1; obs; chk("t2_done_run", Run, 0);
    tick; force_done = 0; obs; chk("t2_run2", Run, 1); chk("t2_instr2", InstrOut, 9'o202);
    tick; obs; chk("t2_pc1", PC, 1);

    // 3: address wrap, 5th Run is word 0 again
    do_reset(9'o001, 9'o002, 9'o003, 9'o004, 1);
    for (int k = 0; k < 5; k++) begin
      wait_run("t3_run", 8);
      chk("t3_instr", InstrOut, 9'o001 + (k % 4));
      tick; obs; chk("t3_pc", PC, k % 4);
    end

    // 4: reset pulse during WAIT
    do_reset(9'o010, 9'o020, 9'o030, 9'o040, 0);
    tick; obs;
    tick; obs; chk("t4_run", Run, 1);
    tick; obs; chk("t4_busy", Busy, 1);
    tick; Resetn = 0; obs;
    tick; Resetn = 1; obs;
    chk("t4_rst_run", Run, 0); chk("t4_rst_busy", Busy, 0);
    chk("t4_rst_pc", PC, 0); chk("t4_rst_maddr", MemAddr, 0);
    tick; obs; chk("t4_c2_run", Run, 0);
    tick; obs; chk("t4_rerun", Run, 1); chk("t4_reinstr", InstrOut, 9'o010);
    tick; obs; chk("t4_pc", PC, 0);

    // 5: Enable dropped in WAIT, then Done
    do_reset(9'o010, 9'o020, 9'o030, 9'o040, 0);
    tick; obs;
    tick; obs; chk("t5_run", Run, 1);
    tick; Enable = 0; obs; chk("t5_busy", Busy, 1);
    tick; force_done = 1; obs;
    tick; force_done = 0; obs; chk("t5_busy_fall", Busy, 0); chk("t5_maddr", MemAddr, 2);
    for (int i = 0; i < 6; i++) begin tick; obs; chk("t5_no_run", Run, 0); end
    chk("t5_maddr_frozen", MemAddr, 2);
    tick; force_done = 1; obs;            // Done while idle is ignored
    tick; force_done = 0; obs; chk("t5_idle_done", Busy, 0);

    // 6: opcode 3'b111 after a mv
    do_reset(9'o010, 9'o700, 9'o000, 9'o000, 1);
    tick; obs;
    tick; obs; chk("t6_run0", Run, 1); chk("t6_instr0", InstrOut, 9'o010);
`ifdef HALT_DETECT_EN
    for (int i = 0; i < 6; i++) begin tick; obs; chk("t6_no_run", Run, 0); end
    chk("t6_halted", Halted, 1);
`else
    wait_run("t6_run700", 6); chk("t6_instr700", InstrOut, 9'o700);
    tick; obs; chk("t6_pc1", PC, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
